input_event_router: RTL and testbench
=====================================

// Module: input_event_router
// PURPOSE
//  Parametrised router for user input events. It converts the synchronised, debounced button levels
//  into per-mode press pulses and long-press pulses, and steers them to the one-hot selected mode block.
//  It sits between the button conditioning logic and the mode blocks (clock/countup/countdown/alarm/setup).
//  Mode changes are guarded, so the press that causes a switch never leaks into the new mode.
// PARAMETERS
//  NUM_MODES    5      number of one-hot mode lines / destination blocks
//  NUM_BTNS     4      number of buttons; index 0=start, 1=reset, 2=btn2, 3=btn1
//  LONG_CYCLES  200    hold cycles (>=2) after the press edge before the long-press pulse fires
//  GUARD_CYCLES 4      cycles all events are suppressed after a mode change (0 = no blanking)
// PORTS
//  clk        in   1                  system clock, all logic rising-edge
//  rst_n      in   1                  asynchronous active-low reset
//  mode_sel   in   NUM_MODES          one-hot mode select, sync to clk
//  btn_in     in   NUM_BTNS           debounced button levels, 1=pressed, sync to clk
//  evt_pulse  out  NUM_MODES*NUM_BTNS press pulse, bit m*NUM_BTNS+b = button b for mode m
//  evt_long   out  NUM_MODES*NUM_BTNS long-press pulse, same indexing
//  guard_busy out  1                  1 while the guard counter is nonzero
//  mode_err   out  1                  1 while mode_sel is not exactly one-hot
// BEHAVIOUR
//  Reset values
//  - All outputs 0.
//  - Internal: btn_q=0, arm=0, mode_q=0, guard_cnt=0, hold_cnt=0, long_done=0.
//  - Buttons held through reset are ignored until released (arm=0).
//  Registers and definitions
//  - All outputs are registered. Every pulse is high for exactly one cycle.
//  - btn_q<=btn_in every edge.
//  - rise[b]=btn_in[b]&~btn_q[b].
//  - valid = mode_sel is one-hot (popcount==1). mode_err<=~valid.
//  - chg = (mode_sel!=mode_q). mode_q<=mode_sel every edge.
//  Arm rules, per button
//  - arm[b]<=1 when btn_in[b]==0.
//  - arm[b]<=0 when chg and btn_in[b]==1.
//  - Otherwise arm[b] holds.
//  Guard counter
//  - On chg: guard_cnt<=GUARD_CYCLES.
//  - Otherwise, if nonzero: guard_cnt<=guard_cnt-1.
//  - Re-trigger during guard reloads the full value. guard_busy<=(next guard_cnt!=0).
//  - ok = valid & ~chg & (guard_cnt==0).
//  Press event
//  - At edge k, if rise[b] & arm[b] & ok, then evt_pulse[m*NUM_BTNS+b]<=1, m = index of the mode_sel bit.
//  - Latency: 1 edge after btn_in is first sampled high.
//  Long-press event
//  - hold_cnt[b], width $clog2(LONG_CYCLES+1), saturating.
//  - Cleared when btn_in[b]==0 or arm[b]==0.
//  - Otherwise increments while btn_in[b] & arm[b] & ok.
//  - When it reaches LONG_CYCLES and long_done[b]==0: evt_long bit <=1, long_done[b]<=1.
//  - long_done clears only on release. Exactly one long pulse per hold; no auto-repeat.
//  - A press pulse always precedes its long pulse.
//  Boundary cases
//  - Simultaneous buttons are independent; several evt_pulse bits may be high in the same cycle.
//  - Mode change while a button is held: the button is disarmed, no long pulse, and the next press
//    needs a release first.
//  - Invalid mode: no events. Hold counters do not advance.
//  - Invalid-to-valid transition counts as chg.
//  - rst_n low mid-hold: everything clears immediately. No event after release of rst_n until the
//    button is released and re-pressed.
// TESTING
//  T1: rst_n deassert, mode_sel=5'b00010, btn_in[0] 0->1 at edge 10
//      -> evt_pulse[1*4+0] high cycle 10-11 only, no other bits.
//  T2: LONG_CYCLES=8, hold btn_in[2] 20 cycles in mode bit 3 -> one evt_pulse[14], then one evt_long[14]
//      8 cycles later, none after; re-press repeats.
//  T3: Hold btn_in[3], change mode_sel 00001->00100 mid-hold
//      -> guard_busy high 4 cycles, no evt_long, no pulse until release+re-press.
//  T4: mode_sel=00000 then 00110 with presses -> mode_err=1, zero events; restore 00100
//      -> events resume after guard.
//  T5: Press btn_in[0] and btn_in[1] on the same edge -> both bits pulse the same cycle.
//      rst_n low during hold -> outputs 0 at once, no pulse until release and re-press.

Source files
------------

// File: rtl/input_event_router.sv
// Input event router: turns debounced button levels into press and
// long-press pulses, steered to the one-hot selected mode block.
module input_event_router #(
  parameter int NUM_MODES    = 5,
  parameter int NUM_BTNS     = 4,
  parameter int LONG_CYCLES  = 200,
  parameter int GUARD_CYCLES = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MODES-1:0]          mode_sel,
  input  logic [NUM_BTNS-1:0]           btn_in,
  output logic [NUM_MODES*NUM_BTNS-1:0] evt_pulse,
  output logic [NUM_MODES*NUM_BTNS-1:0] evt_long,
  output logic                          guard_busy,
  output logic                          mode_err
);

  localparam int NE = NUM_MODES * NUM_BTNS;
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam int GW = (GUARD_CYCLES > 0) ?
                      $clog2(GUARD_CYCLES + 1) : 1;
  localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES);
  localparam logic [GW-1:0] GLOAD = GW'(GUARD_CYCLES);

  logic [NUM_BTNS-1:0]          btn_q;
  logic [NUM_BTNS-1:0]          arm_q, arm_d;
  logic [NUM_MODES-1:0]         mode_q;
  logic [GW-1:0]                guard_q, guard_d;
  logic [NUM_BTNS-1:0][HW-1:0]  hold_q, hold_d;
  logic [NUM_BTNS-1:0]          done_q, done_d;
  logic [NE-1:0]                pulse_q, pulse_d;
  logic [NE-1:0]                long_q, long_d;
  logic                         busy_q, err_q;

  logic [NUM_BTNS-1:0] rise, press, lfire;
  logic                valid, chg, ok;

  // Qualify edges, track arming and guard, and build next pulses.
  // Hold counting only starts on a press that actually pulsed, so a
  // long pulse can never appear without its press pulse before it.
  always_comb begin
    rise    = btn_in & ~btn_q;
    valid   = $onehot(mode_sel);
    chg     = (mode_sel != mode_q);
    ok      = valid & ~chg & (guard_q == '0);
    guard_d = guard_q;
    if (chg)
      guard_d = GLOAD;
    else if (guard_q != '0)
      guard_d = guard_q - GW'(1);
    arm_d   = arm_q;
    hold_d  = hold_q;
    done_d  = done_q;
    press   = '0;
    lfire   = '0;
    pulse_d = '0;
    long_d  = '0;
    for (int b = 0; b < NUM_BTNS; b++) begin
      if (!btn_in[b])
        arm_d[b] = 1'b1;
      else if (chg)
        arm_d[b] = 1'b0;
      press[b] = rise[b] & arm_q[b] & ok;
      lfire[b] = btn_in[b] & arm_q[b] & ok &
                 (hold_q[b] == HMAX) & ~done_q[b];
      if (!btn_in[b] || !arm_q[b])
        hold_d[b] = '0;
      else if (ok && hold_q[b] != HMAX &&
               (hold_q[b] != '0 || press[b]))
        hold_d[b] = hold_q[b] + HW'(1);
      if (!btn_in[b])
        done_d[b] = 1'b0;
      else if (lfire[b])
        done_d[b] = 1'b1;
    end
    for (int m = 0; m < NUM_MODES; m++) begin
      for (int b = 0; b < NUM_BTNS; b++) begin
        pulse_d[m*NUM_BTNS+b] = mode_sel[m] & press[b];
        long_d[m*NUM_BTNS+b]  = mode_sel[m] & lfire[b];
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_q   <= '0;
      arm_q   <= '0;
      mode_q  <= '0;
      guard_q <= '0;
      hold_q  <= '0;
      done_q  <= '0;
      pulse_q <= '0;
      long_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      btn_q   <= btn_in;
      arm_q   <= arm_d;
      mode_q  <= mode_sel;
      guard_q <= guard_d;
      hold_q  <= hold_d;
      done_q  <= done_d;
      pulse_q <= pulse_d;
      long_q  <= long_d;
      busy_q  <= (guard_d != '0);
      err_q   <= ~valid;
    end
  end

  assign evt_pulse  = pulse_q;
  assign evt_long   = long_q;
  assign guard_busy = busy_q;
  assign mode_err   = err_q;

endmodule

// File: tb/tb_input_event_router.sv
// Directed bench for input_event_router: vector table plus
// hand-written reset-during-hold sequence.
module tb_input_event_router;

  logic        clk;
  logic        rst_n;
  logic [4:0]  mode_sel;
  logic [3:0]  btn_in;
  logic [19:0] evt_pulse;
  logic [19:0] evt_long;
  logic        guard_busy;
  logic        mode_err;

  int n_pass = 0;
  int n_tot  = 0;

  typedef struct {
    logic [4:0]  m;
    logic [3:0]  b;
    logic [19:0] p;
    logic [19:0] l;
    logic        bz;
    logic        e;
  } vec_t;

  vec_t vecs[$];

  input_event_router #(
    .NUM_MODES(5),
    .NUM_BTNS(4),
    .LONG_CYCLES(8),
    .GUARD_CYCLES(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .mode_sel(mode_sel),
    .btn_in(btn_in),
    .evt_pulse(evt_pulse),
    .evt_long(evt_long),
    .guard_busy(guard_busy),
    .mode_err(mode_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [19:0] got,
                     input logic [19:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic add(input logic [4:0] m, input logic [3:0] b,
                     input logic [19:0] p, input logic [19:0] l,
                     input logic bz, input logic e);
    vec_t v;
    v.m = m; v.b = b; v.p = p; v.l = l; v.bz = bz; v.e = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic [4:0] m, input logic [3:0] b);
    mode_sel = m;
    btn_in   = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // T1: guard after reset (mode_q starts 0), then press btn0 in mode 1
    add(5'b00010, 4'b0000, 20'h0, 20'h0, 1, 0);
    for (int i = 0; i < 3; i++)
      add(5'b00010, 4'b0000, 20'h0, 20'h0, 1, 0);
    for (int i = 0; i < 5; i++)
      add(5'b00010, 4'b0000, 20'h0, 20'h0, 0, 0);
    add(5'b00010, 4'b0001, 20'h00010, 20'h0, 0, 0);
    add(5'b00010, 4'b0000, 20'h0, 20'h0, 0, 0);
    // T5a: simultaneous press of btn0 and btn1
    add(5'b00010, 4'b0011, 20'h00030, 20'h0, 0, 0);
    add(5'b00010, 4'b0011, 20'h0, 20'h0, 0, 0);
    // T2: mode 3, long press on btn2, then re-press
    for (int i = 0; i < 4; i++)
      add(5'b01000, 4'b0000, 20'h0, 20'h0, 1, 0);
    add(5'b01000, 4'b0000, 20'h0, 20'h0, 0, 0);
    add(5'b01000, 4'b0100, 20'h04000, 20'h0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(5'b01000, 4'b0100, 20'h0, 20'h0, 0, 0);
    add(5'b01000, 4'b0100, 20'h0, 20'h04000, 0, 0);
    for (int i = 0; i < 11; i++)
      add(5'b01000, 4'b0100, 20'h0, 20'h0, 0, 0);
    add(5'b01000, 4'b0000, 20'h0, 20'h0, 0, 0);
    add(5'b01000, 4'b0100, 20'h04000, 20'h0, 0, 0);
    for (int i = 0; i < 7; i++)
      add(5'b01000, 4'b0100, 20'h0, 20'h0, 0, 0);
    add(5'b01000, 4'b0100, 20'h0, 20'h04000, 0, 0);
    add(5'b01000, 4'b0000, 20'h0, 20'h0, 0, 0);
    // T3: hold btn3 in mode 0, switch to mode 2 mid-hold
    for (int i = 0; i < 4; i++)
      add(5'b00001, 4'b0000, 20'h0, 20'h0, 1, 0);
    add(5'b00001, 4'b0000, 20'h0, 20'h0, 0, 0);
    add(5'b00001, 4'b1000, 20'h00008, 20'h0, 0, 0);
    for (int i = 0; i < 3; i++)
      add(5'b00001, 4'b1000, 20'h0, 20'h0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(5'b00100, 4'b1000, 20'h0, 20'h0, 1, 0);
    for (int i = 0; i < 12; i++)
      add(5'b00100, 4'b1000, 20'h0, 20'h0, 0, 0);
    add(5'b00100, 4'b0000, 20'h0, 20'h0, 0, 0);
    add(5'b00100, 4'b1000, 20'h00800, 20'h0, 0, 0);
    add(5'b00100, 4'b0000, 20'h0, 20'h0, 0, 0);
    // T4: invalid modes suppress events, then recover after guard
    add(5'b00000, 4'b0000, 20'h0, 20'h0, 1, 1);
    add(5'b00000, 4'b0001, 20'h0, 20'h0, 1, 1);
    add(5'b00000, 4'b0000, 20'h0, 20'h0, 1, 1);
    add(5'b00110, 4'b0000, 20'h0, 20'h0, 1, 1);
    add(5'b00110, 4'b0010, 20'h0, 20'h0, 1, 1);
    add(5'b00110, 4'b0000, 20'h0, 20'h0, 1, 1);
    for (int i = 0; i < 4; i++)
      add(5'b00100, 4'b0000, 20'h0, 20'h0, 1, 0);
    add(5'b00100, 4'b0000, 20'h0, 20'h0, 0, 0);
    add(5'b00100, 4'b0100, 20'h00400, 20'h0, 0, 0);
    add(5'b00100, 4'b0000, 20'h0, 20'h0, 0, 0);

    rst_n    = 1'b0;
    mode_sel = 5'b00010;
    btn_in   = 4'b0000;
    #12;
    chk("rst_pulse", evt_pulse, 20'h0);
    chk("rst_long", evt_long, 20'h0);
    chk("rst_busy", {19'h0, guard_busy}, 20'h0);
    chk("rst_err", {19'h0, mode_err}, 20'h0);
    @(posedge clk);
    #2 rst_n = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].m, vecs[i].b);
      chk($sformatf("v%0d_pulse", i), evt_pulse, vecs[i].p);
      chk($sformatf("v%0d_long", i), evt_long, vecs[i].l);
      chk($sformatf("v%0d_busy", i),
          {19'h0, guard_busy}, {19'h0, vecs[i].bz});
      chk($sformatf("v%0d_err", i),
          {19'h0, mode_err}, {19'h0, vecs[i].e});
    end

    // T5b: press btn0+btn1 in mode 2, reset while pulse is high
    step(5'b00100, 4'b0011);
    chk("rh_press", evt_pulse, 20'h00300);
    rst_n = 1'b0;
    #1;
    chk("rh_async_pulse", evt_pulse, 20'h0);
    chk("rh_async_err", {19'h0, mode_err}, 20'h0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(5'b00100, 4'b0011);
      chk($sformatf("rh_held%0d_p", i), evt_pulse, 20'h0);
      chk($sformatf("rh_held%0d_l", i), evt_long, 20'h0);
    end
    step(5'b00100, 4'b0000);
    chk("rh_rel", evt_pulse, 20'h0);
    step(5'b00100, 4'b0000);
    step(5'b00100, 4'b0001);
    chk("rh_repress", evt_pulse, 20'h00100);
    step(5'b00100, 4'b0000);
    chk("rh_after", evt_pulse, 20'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
